// File: rtl/aes_key_expander_if.sv
// Request/response bundle between an AES round controller and the on-the-fly
// key expander: key load and advance requests in, current round key and status out.
interface aes_key_expander_if #(
  parameter int KEY_W = 128
);
  logic             key_load;
  logic [KEY_W-1:0] cipher_key;
  logic             next;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       round_num;
  logic             key_valid;
  logic             last;
  logic             busy;

  modport master (
    output key_load, cipher_key, next,
    input  round_key, round_num, key_valid, last, busy
  );

  modport slave (
    input  key_load, cipher_key, next,
    output round_key, round_num, key_valid, last, busy
  );
endinterface

// File: rtl/aes_key_expander.sv
// On-the-fly AES-128 key schedule emitting round keys 0..10, one per request.
// Optional AES_KEY_CACHE_EN keeps all 11 keys and walks them back 9..0 after the last.
module aes_key_expander #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10
) (
  input logic             clk,
  input logic             rst,
  aes_key_expander_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // Forward S-box, byte x lives at bits [8x +: 8] of this ascending vector.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    LAST
`ifdef AES_KEY_CACHE_EN
    , WALK
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic [7:0]       rcon_q, rcon_d;

  logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [KEY_W-1:0] next_key;
  logic [7:0]       rcon_next;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key  = {n0, n1, n2, n3};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

`ifdef AES_KEY_CACHE_EN
  logic [KEY_W-1:0] cache [NUM_ROUNDS+1];
  logic             cache_we;
  logic [3:0]       cache_waddr;
  logic [KEY_W-1:0] cache_wdata;
`endif

  // NOTE: every combinational output gets a default first so no path through
  // the case/if structure leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    valid_d = valid_q;
    rcon_d  = rcon_q;
`ifdef AES_KEY_CACHE_EN
    cache_we    = 1'b0;
    cache_waddr = '0;
    cache_wdata = next_key;
`endif
    if (bus.key_load) begin
      state_d = ACTIVE;
      key_d   = bus.cipher_key;
      num_d   = '0;
      valid_d = 1'b1;
      rcon_d  = 8'h01;
`ifdef AES_KEY_CACHE_EN
      cache_we    = 1'b1;
      cache_wdata = bus.cipher_key;
`endif
    end else if (bus.next) begin
      case (state_q)
        ACTIVE: begin
          key_d  = next_key;
          num_d  = num_q + 4'd1;
          rcon_d = rcon_next;
          if (num_q == LAST_ROUND - 4'd1) state_d = LAST;
`ifdef AES_KEY_CACHE_EN
          cache_we    = 1'b1;
          cache_waddr = num_q + 4'd1;
`endif
        end
        LAST: begin
`ifdef AES_KEY_CACHE_EN
          state_d = WALK;
          num_d   = LAST_ROUND - 4'd1;
          key_d   = cache[NUM_ROUNDS-1];
`else
          // The last key stays on round_key; only the status is cleared.
          state_d = IDLE;
          num_d   = '0;
          valid_d = 1'b0;
`endif
        end
`ifdef AES_KEY_CACHE_EN
        WALK: begin
          if (num_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            num_d = num_q - 4'd1;
            key_d = cache[num_q - 4'd1];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      rcon_q  <= rcon_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  // NOTE: the cache is deliberately not reset; an entry is only read after a
  // load has rewritten it, and leaving it reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (cache_we) cache[cache_waddr] <= cache_wdata;
  end
`endif

  assign bus.round_key = key_q;
  assign bus.round_num = num_q;
  assign bus.key_valid = valid_q;
  assign bus.last      = valid_q && (num_q == LAST_ROUND);
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a FIPS-197 word-level key
// schedule model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] sched  [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      r = inv;
      s = inv;
      for (int n = 0; n < 4; n++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [134:0] snap();
    return {bus.round_key, bus.round_num, bus.key_valid, bus.last, bus.busy};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic load, input logic [127:0] key, input logic nx);
    bus.key_load   = load;
    bus.cipher_key = key;
    bus.next       = nx;
    tick();
    bus.key_load = 1'b0;
    bus.next     = 1'b0;
  endtask

  task automatic test_reset();
    logic [134:0] exp;
    rst = 1'b1;
    bus.key_load = 1'b0; bus.cipher_key = '0; bus.next = 1'b0;
    repeat (2) tick();
    exp = '0;
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", snap(), exp);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL idle_ignores_next got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_fips_load();
    logic [134:0] exp;
    drive(1'b1, FIPS_KEY, 1'b0);
    exp = {FIPS_KEY, 4'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL fips_load got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_one_next();
    logic [134:0] exp;
    drive(1'b0, '0, 1'b1);
    exp = {FIPS_R1, 4'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL fips_round1 got=%h exp=%h", snap(), exp);
    end
    repeat (5) tick();
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL hold_without_next got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [134:0] exp;
    build_schedule(FIPS_KEY);
    drive(1'b1, FIPS_KEY, 1'b0);
    bus.next = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      tick();
      if (r == 10) bus.next = 1'b0;
      exp = {sched[r], 4'(r), 1'b1, (r == 10), 1'b1};
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL b2b_round%0d got=%h exp=%h", r, snap(), exp);
      end
    end
    exp = {FIPS_R10, 4'd10, 1'b1, 1'b1, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL fips_round10 got=%h exp=%h", snap(), exp);
    end
    repeat (3) tick();
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL hold_in_last got=%h exp=%h", snap(), exp);
    end
    drive(1'b0, '0, 1'b1);
`ifdef AES_KEY_CACHE_EN
    exp = {sched[9], 4'd9, 1'b1, 1'b0, 1'b1};
`else
    exp = {FIPS_R10, 4'd0, 1'b0, 1'b0, 1'b0};
`endif
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL after_last got=%h exp=%h", snap(), exp);
    end
  endtask

`ifdef AES_KEY_CACHE_EN
  task automatic test_cache_walk();
    logic [134:0] exp;
    logic [127:0] k2, k3;
    for (int r = 8; r >= 0; r--) begin
      drive(1'b0, '0, 1'b1);
      exp = {sched[r], 4'(r), 1'b1, 1'b0, 1'b1};
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL walk_round%0d got=%h exp=%h", r, snap(), exp);
      end
    end
    drive(1'b0, '0, 1'b1);
    exp = {FIPS_KEY, 4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL walk_to_idle got=%h exp=%h", snap(), exp);
    end
    k2 = rand_key();
    drive(1'b1, k2, 1'b0);
    repeat (12) drive(1'b0, '0, 1'b1);
    k3 = rand_key();
    build_schedule(k3);
    drive(1'b1, k3, 1'b1);
    exp = {k3, 4'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL load_during_walk got=%h exp=%h", snap(), exp);
    end
    drive(1'b0, '0, 1'b1);
    exp = {sched[1], 4'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL walk_reload_round1 got=%h exp=%h", snap(), exp);
    end
  endtask
`endif

  task automatic test_collision();
    logic [134:0] exp;
    logic [127:0] ka, kb;
    ka = rand_key();
    kb = rand_key();
    build_schedule(ka);
    drive(1'b1, ka, 1'b0);
    repeat (5) drive(1'b0, '0, 1'b1);
    exp = {sched[5], 4'd5, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL collide_pre_round5 got=%h exp=%h", snap(), exp);
    end
    build_schedule(kb);
    drive(1'b1, kb, 1'b1);
    exp = {kb, 4'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL collide_load_wins got=%h exp=%h", snap(), exp);
    end
    for (int r = 1; r <= 10; r++) begin
      drive(1'b0, '0, 1'b1);
      exp = {sched[r], 4'(r), 1'b1, (r == 10), 1'b1};
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL collide_round%0d got=%h exp=%h", r, snap(), exp);
      end
    end
  endtask

  task automatic test_random();
    logic [134:0] exp;
    logic [127:0] k;
    logic         nx;
    int           num;
    for (int it = 0; it < 4; it++) begin
      k = rand_key();
      build_schedule(k);
      // Load with next also high: from LAST (or ACTIVE) the load must win.
      drive(1'b1, k, 1'b1);
      num = 0;
      exp = {k, 4'd0, 1'b1, 1'b0, 1'b1};
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL rand%0d_load got=%h exp=%h", it, snap(), exp);
      end
      for (int c = 0; c < 100 && num < 10; c++) begin
        nx = 1'($urandom_range(0, 1));
        drive(1'b0, '0, nx);
        if (nx) num++;
        exp = {sched[num], 4'(num), 1'b1, (num == 10), 1'b1};
        checks++;
        if (snap() !== exp) begin
          failures++; $display("FAIL rand%0d_cycle%0d got=%h exp=%h", it, c, snap(), exp);
        end
      end
      checks++;
      if (num != 10) begin
        failures++; $display("FAIL rand%0d_budget got=%0d exp=10", it, num);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [134:0] exp;
    drive(1'b1, rand_key(), 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1);
    #3 rst = 1'b1;
    #1;
    exp = '0;
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", snap(), exp);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL after_reset_release got=%h exp=%h", snap(), exp);
    end
    build_schedule(FIPS_KEY);
    drive(1'b1, FIPS_KEY, 1'b0);
    drive(1'b0, '0, 1'b1);
    exp = {FIPS_R1, 4'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL reset_rcon_restart got=%h exp=%h", snap(), exp);
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips_load();
    test_one_next();
    test_back_to_back();
`ifdef AES_KEY_CACHE_EN
    test_cache_walk();
`endif
    test_collision();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
